// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit position borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (bin & ~(a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per cycle LSB first, with
// valid/ready handshakes on operands and result.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output state_t           state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid is never withdrawn by the DUT before its transfer, and ready is a
  // pure function of the FSM state so it never depends on the partner's valid.

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             d_bit, br_next;
  logic             accept;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_next)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= bin;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_q  <= a_q >> 1;
          b_q  <= b_q >> 1;
          br_q <= br_next;
          // LSB arrives first, so after WIDTH shifts it has reached bit 0.
          diff <= {d_bit, diff[WIDTH-1:1]};
          if (cnt_q == LAST) begin
            bout <= br_next;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4 (plus one WIDTH=8 vector).
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid, out_ready, bin;
  logic [3:0] a, b;
  logic       in_ready, out_valid, bout;
  logic [3:0] diff;
  state_t     state_dbg;

  logic       in_valid8, out_ready8, bin8;
  logic [7:0] a8, b8;
  logic       in_ready8, out_valid8, bout8;
  logic [7:0] diff8;
  state_t     state_dbg8;

  int compared   = 0;
  int mismatched = 0;
  logic [4:0] exp_q[$];

  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .state_dbg(state_dbg)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .state_dbg(state_dbg8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: one op on the WIDTH=4 instance, entered at a falling edge with DUT idle.
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tbin,
                     input logic [4:0] exp_res, input int bp, input bit rnd_ready);
    logic [4:0] e;
    int lat;
    int n;
    exp_q.push_back(exp_res);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; a = ta; b = tb_; bin = tbin; out_ready = 1'b0;
    @(negedge clk);
    // Scramble operands after acceptance; the DUT must ignore them.
    in_valid = 1'b0; a = ~ta; b = ~tb_; bin = ~tbin;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 32'd5);
    chk("out_valid", {31'b0, out_valid}, 32'd1);
    e = exp_q.pop_front();
    chk("result", {27'b0, bout, diff}, {27'b0, e});
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_result", {27'b0, bout, diff}, {27'b0, e});
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    if (rnd_ready) begin
      n = 0;
      while (out_valid && n < 50) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (out_valid) chk("rnd_hold", {27'b0, bout, diff}, {27'b0, e});
        n++;
      end
      chk("rnd_drain", {31'b0, out_valid}, 32'd0);
    end else begin
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_out_valid", {31'b0, out_valid}, 32'd0);
    end
    out_ready = 1'b0;
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [4:0] model;
    int lat8;
    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; out_ready8 = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", {27'b0, bout, diff}, 32'd0);
    chk("rst_state", {30'b0, state_dbg}, {30'b0, IDLE});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors, expected values worked by hand.
    op4(4'd9, 4'd3, 1'b0, 5'h06, 0, 1'b0);
    op4(4'd3, 4'd9, 1'b0, 5'h1A, 0, 1'b0);
    op4(4'd0, 4'd0, 1'b1, 5'h1F, 0, 1'b0);
    op4(4'hF, 4'hF, 1'b0, 5'h00, 0, 1'b0);
    op4(4'd12, 4'd5, 1'b1, 5'h06, 6, 1'b0);

    // Reset two cycles into RUN aborts the op.
    in_valid = 1'b1; a = 4'd7; b = 4'd1; bin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_abort_state", {30'b0, state_dbg}, {30'b0, RUN});
    #2 reset = 1'b1;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_result", {27'b0, bout, diff}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    op4(4'd5, 4'd2, 1'b0, 5'h03, 0, 1'b0);

    // Exhaustive sweep against an arithmetic reference, random result back-pressure.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          model = 5'(ia) - 5'(ib) - 5'(ic);
          op4(4'(ia), 4'(ib), 1'(ic), model, 0, 1'b1);
        end
      end
    end

    // WIDTH=8: 0x00 - 0x01 borrows all the way through.
    chk("w8_in_ready", {31'b0, in_ready8}, 32'd1);
    in_valid8 = 1'b1; a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
    lat8 = 1;
    while (!out_valid8 && lat8 < 30) begin
      @(negedge clk);
      lat8++;
    end
    chk("w8_latency", lat8, 32'd9);
    chk("w8_result", {23'b0, bout8, diff8}, 32'h1FF);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk("w8_release", {30'b0, out_valid8, in_ready8}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
